// File: rtl/io_input_unit.sv
// -----------------------------------------------------------------------------
// io_input_unit
//   Board-input front end for the CPU io0 read path.
//   - Switch pins pass through a SYNC_STAGES flop synchronizer (no debounce).
//   - Key pins (active-low) are synchronized, debounced per key, and presented
//     as an active-high level vector.
//   - A debounced press (level 0->1) latches a sticky pending bit that is
//     cleared by a key-status read; a press on the clearing edge wins.
//   - Reads return a registered 32-bit word one cycle after the strobe.
//   Optional feature macro: IO_KEY_IRQ_EN adds the o_irq output, a registered
//   OR of the pending bits. Without it the port and register do not exist.
// -----------------------------------------------------------------------------
module io_input_unit #(
    parameter int NUM_SW          = 18,
    parameter int NUM_KEY         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SW-1:0]  i_sw_in,
    input  logic [NUM_KEY-1:0] i_key_n_in,
    input  logic               i_rd_en,
    input  logic               i_rd_sel,
    output logic [31:0]        o_rd_data,
    output logic [NUM_KEY-1:0] o_key_level
`ifdef IO_KEY_IRQ_EN
    ,
    output logic               o_irq
`endif
);

    // Counter must be able to hold DEBOUNCE_CYCLES-1; sized one value wider so
    // a DEBOUNCE_CYCLES of 1 still yields a legal 1-bit counter.
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Synchronizer chains. Switches reset to 0, keys reset to 1 (released),
    // so leaving reset never looks like a key press.
    // -------------------------------------------------------------------------
    logic [NUM_SW-1:0]  r_sw_chain  [SYNC_STAGES];
    logic [NUM_KEY-1:0] r_key_chain [SYNC_STAGES];
    logic [NUM_SW-1:0]  w_sw_sync;
    logic [NUM_KEY-1:0] w_key_sync;

    // Shift raw pins through the synchronizer flops
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sw_chain[s]  <= '0;
                r_key_chain[s] <= '1;
            end
        end else begin
            r_sw_chain[0]  <= i_sw_in;
            r_key_chain[0] <= i_key_n_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sw_chain[s]  <= r_sw_chain[s-1];
                r_key_chain[s] <= r_key_chain[s-1];
            end
        end
    end

    assign w_sw_sync  = r_sw_chain[SYNC_STAGES-1];
    assign w_key_sync = r_key_chain[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Per-key debounce. A key's level changes only after DEBOUNCE_CYCLES
    // consecutive cycles in which the synchronized pin disagrees with it; any
    // agreeing cycle restarts the count, so the counter never wraps.
    // -------------------------------------------------------------------------
    logic [NUM_KEY-1:0] r_key_level;
    logic [NUM_KEY-1:0] w_level_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEY; gi++) begin : g_key
            logic [CNT_W-1:0] r_cnt;
            logic             w_mismatch;
            logic             w_accept;

            assign w_mismatch       = (~w_key_sync[gi]) != r_key_level[gi];
            assign w_accept         = w_mismatch && (r_cnt == CNT_LAST);
            assign w_level_next[gi] = w_accept ? ~w_key_sync[gi] : r_key_level[gi];

            // Count consecutive mismatched cycles; restart on agreement or accept
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_cnt <= '0;
                end else if (!w_mismatch || w_accept) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Press events. The rising edge is taken from the registered level against
    // a one-cycle-delayed copy, so pending sets the cycle after key_level rises.
    // A status read clears exactly the bits it returned; a press detected on
    // the same edge is OR-ed in afterwards, so it survives to the next read.
    // -------------------------------------------------------------------------
    logic [NUM_KEY-1:0] r_key_level_d;
    logic [NUM_KEY-1:0] r_pending;
    logic [NUM_KEY-1:0] w_rise;
    logic [NUM_KEY-1:0] w_pending_kept;
    logic [NUM_KEY-1:0] w_pending_next;
    logic               w_status_read;

    assign w_status_read  = i_rd_en && i_rd_sel;
    assign w_rise         = r_key_level & ~r_key_level_d;
    assign w_pending_kept = w_status_read ? {NUM_KEY{1'b0}} : r_pending;
    assign w_pending_next = w_pending_kept | w_rise;

    // Register debounced levels, the edge-detect copy and the sticky pending bits
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key_level   <= '0;
            r_key_level_d <= '0;
            r_pending     <= '0;
        end else begin
            r_key_level   <= w_level_next;
            r_key_level_d <= r_key_level;
            r_pending     <= w_pending_next;
        end
    end

    // -------------------------------------------------------------------------
    // Read path. Both words are zero-extended to their field widths; the
    // selected word is captured on the strobe and held until the next one.
    // -------------------------------------------------------------------------
    logic [31:0] r_rd_data;
    logic [31:0] w_sw_word;
    logic [31:0] w_key_word;
    logic [7:0]  w_pending_byte;
    logic [7:0]  w_level_byte;

    assign w_pending_byte = 8'(r_pending);
    assign w_level_byte   = 8'(r_key_level);
    assign w_sw_word      = 32'(w_sw_sync);
    assign w_key_word     = {16'h0000, w_pending_byte, w_level_byte};

    // Capture the selected status word on each read strobe
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= i_rd_sel ? w_key_word : w_sw_word;
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_key_level = r_key_level;

`ifdef IO_KEY_IRQ_EN
    // -------------------------------------------------------------------------
    // Interrupt: registered OR of pending, so it follows pending by one cycle
    // in both directions.
    // -------------------------------------------------------------------------
    logic r_irq;

    // Register the any-pending indication
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_pending;
        end
    end

    assign o_irq = r_irq;
`endif

endmodule
